// File: rtl/izh_pkg.sv
// Shared constants and FSM encoding for the Izhikevich spike/reset stage.
// Float constants are IEEE-754 single precision bit patterns.
package izh_pkg;

   localparam logic [31:0] FP_V_PEAK  = 32'h41F00000;  // 30.0
   localparam logic [31:0] FP_V_INIT  = 32'hC2820000;  // -65.0
   localparam logic [31:0] FP_U_INIT  = 32'hC1500000;  // -13.0
   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [7:0]  FP_NAN_EXP = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 single adder, round-to-nearest-even, with
// denormal, infinity and NaN handling.
module fp_add
   import izh_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_sum
);

   logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
   logic        w_swap, w_sub, w_sticky, w_rnd_up;
   logic [31:0] w_x, w_y;
   logic [7:0]  w_ex, w_ey, w_diff;
   logic [26:0] w_mx, w_my, w_my_sh;
   logic [27:0] w_raw;
   logic [26:0] w_norm;
   logic [4:0]  w_lz, w_sh;
   logic [9:0]  w_exp;
   logic [24:0] w_rnd;

   assign w_nan_a = (i_a[30:23] == FP_NAN_EXP) && (i_a[22:0] != 23'd0);
   assign w_nan_b = (i_b[30:23] == FP_NAN_EXP) && (i_b[22:0] != 23'd0);
   assign w_inf_a = (i_a[30:23] == FP_NAN_EXP) && (i_a[22:0] == 23'd0);
   assign w_inf_b = (i_b[30:23] == FP_NAN_EXP) && (i_b[22:0] == 23'd0);

   always_comb begin
      // x carries the larger magnitude, so the result sign is x's sign
      w_swap = i_b[30:0] > i_a[30:0];
      w_x    = w_swap ? i_b : i_a;
      w_y    = w_swap ? i_a : i_b;
      w_sub  = w_x[31] ^ w_y[31];
      w_ex   = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
      w_ey   = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
      w_mx   = {(w_x[30:23] != 8'd0), w_x[22:0], 3'b000};
      w_my   = {(w_y[30:23] != 8'd0), w_y[22:0], 3'b000};
      w_diff = w_ex - w_ey;

      if (w_diff > 8'd26) begin
         w_my_sh  = 27'd0;
         w_sticky = |w_my;
      end else begin
         w_my_sh  = w_my >> w_diff;
         w_sticky = |(w_my & ((27'd1 << w_diff) - 27'd1));
      end
      w_my_sh[0] = w_my_sh[0] | w_sticky;

      w_raw = w_sub ? ({1'b0, w_mx} - {1'b0, w_my_sh})
                    : ({1'b0, w_mx} + {1'b0, w_my_sh});

      w_lz = 5'd27;
      for (int i = 0; i < 27; i++)
         if (w_raw[i]) w_lz = 5'(26 - i);

      w_exp = {2'b00, w_ex};
      w_sh  = 5'd0;
      if (w_raw[27]) begin
         w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
         w_exp  = w_exp + 10'd1;
      end else begin
         // left shift stops at exponent 1, leaving a denormal
         w_sh   = ({5'd0, w_lz} < w_exp) ? w_lz : 5'(w_exp - 10'd1);
         w_norm = w_raw[26:0] << w_sh;
         w_exp  = w_exp - {5'd0, w_sh};
      end

      w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_rnd    = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
      if (w_rnd[24]) begin
         w_rnd = w_rnd >> 1;
         w_exp = w_exp + 10'd1;
      end

      if (w_exp >= 10'd255)
         o_sum = {w_x[31], 8'hFF, 23'd0};
      else
         o_sum = {w_x[31], (w_rnd[23] ? w_exp[7:0] : 8'd0), w_rnd[22:0]};

      if (w_raw == 28'd0)
         o_sum = {w_x[31] & w_y[31], 31'd0};

      if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (i_a[31] ^ i_b[31])))
         o_sum = FP_QNAN;
      else if (w_inf_a)
         o_sum = i_a;
      else if (w_inf_b)
         o_sum = i_b;
   end

endmodule

// File: rtl/fp_ge.sv
// Combinational a >= b on IEEE-754 single. NaN on either side gives 0,
// +0 and -0 compare equal, denormals ordered by raw magnitude.
module fp_ge
   import izh_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_ge
);

   logic w_nan_a, w_nan_b, w_zeros;

   assign w_nan_a = (i_a[30:23] == FP_NAN_EXP) && (i_a[22:0] != 23'd0);
   assign w_nan_b = (i_b[30:23] == FP_NAN_EXP) && (i_b[22:0] != 23'd0);
   assign w_zeros = (i_a[30:0] == 31'd0) && (i_b[30:0] == 31'd0);

   always_comb begin
      o_ge = 1'b0;
      if (w_nan_a || w_nan_b)
         o_ge = 1'b0;
      else if (w_zeros)
         o_ge = 1'b1;
      else if (i_a[31] != i_b[31])
         o_ge = ~i_a[31];
      else if (!i_a[31])
         o_ge = i_a[30:0] >= i_b[30:0];
      else
         o_ge = i_a[30:0] <= i_b[30:0];
   end

endmodule

// File: rtl/izh_spike_reset.sv
// Izhikevich spike check and reset stage: commits one (v,u) step per
// handshake, applying v<-c, u<-u+d when v reaches the peak.
module izh_spike_reset
   import izh_pkg::*;
#(
   parameter logic [31:0] V_PEAK = FP_V_PEAK,
   parameter logic [31:0] V_INIT = FP_V_INIT,
   parameter logic [31:0] U_INIT = FP_U_INIT,
   parameter int          CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      post_v,
   input  logic [31:0]      post_u,
   input  logic [31:0]      c,
   input  logic [31:0]      d,
   output logic [31:0]      v_q,
   output logic [31:0]      u_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             spike,
   output logic [CNT_W-1:0] spike_count,
   output logic [CNT_W-1:0] step_count
);

   state_t           r_state, w_state_n;
   logic             w_capture, w_commit;
   logic [31:0]      r_pv, r_pu, r_c, r_d;
   logic [31:0]      r_v, r_u;
   logic             r_spike;
   logic [CNT_W-1:0] r_spk_cnt, r_step_cnt;
   logic             w_spike_n;
   logic [31:0]      w_u_reset;

   fp_ge u_ge (
      .i_a  (r_pv),
      .i_b  (V_PEAK),
      .o_ge (w_spike_n)
   );

   fp_add u_add (
      .i_a   (r_pu),
      .i_b   (r_d),
      .o_sum (w_u_reset)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_capture = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_capture = 1'b1;
               w_state_n = EVAL;
            end
         end
         EVAL: begin
            w_commit  = 1'b1;
            w_state_n = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
      // soft clear overrides any pending capture or commit
      if (soft_clr) begin
         w_state_n = IDLE;
         w_capture = 1'b0;
         w_commit  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pv <= 32'd0;
         r_pu <= 32'd0;
         r_c  <= 32'd0;
         r_d  <= 32'd0;
      end else if (w_capture) begin
         r_pv <= post_v;
         r_pu <= post_u;
         r_c  <= c;
         r_d  <= d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v        <= V_INIT;
         r_u        <= U_INIT;
         r_spike    <= 1'b0;
         r_spk_cnt  <= '0;
         r_step_cnt <= '0;
      end else if (soft_clr) begin
         r_v        <= V_INIT;
         r_u        <= U_INIT;
         r_spike    <= 1'b0;
         r_spk_cnt  <= '0;
         r_step_cnt <= '0;
      end else if (w_commit) begin
         r_v        <= w_spike_n ? r_c : r_pv;
         r_u        <= w_spike_n ? w_u_reset : r_pu;
         r_spike    <= w_spike_n;
         r_step_cnt <= r_step_cnt + 1'b1;
         if (w_spike_n && (r_spk_cnt != '1))
            r_spk_cnt <= r_spk_cnt + 1'b1;
      end
   end

   assign v_q         = r_v;
   assign u_q         = r_u;
   assign spike       = r_spike;
   assign spike_count = r_spk_cnt;
   assign step_count  = r_step_cnt;

endmodule

// File: tb/tb_izh_spike_reset.sv
// Randomized bench for izh_spike_reset against a real-arithmetic model;
// a second instance with a zero peak covers the signed-zero threshold.
module tb_izh_spike_reset;

   localparam int          CW     = 4;
   localparam logic [31:0] PEAK0  = 32'h41F00000;
   localparam logic [31:0] PEAK1  = 32'h00000000;
   localparam logic [31:0] VINIT  = 32'hC2820000;
   localparam logic [31:0] UINIT  = 32'hC1500000;

   logic          clk = 1'b0;
   logic          rst_n, soft_clr, in_valid, out_ready;
   logic [31:0]   post_v, post_u, c, d;
   logic          in_ready, out_valid, spike;
   logic [31:0]   v_q, u_q;
   logic [CW-1:0] spike_count, step_count;
   logic          z_in_ready, z_out_valid, z_spike;
   logic [31:0]   z_v_q, z_u_q;
   logic [CW-1:0] z_spike_count, z_step_count;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_v [2];
   logic [31:0] m_u [2];
   int          m_spk [2];
   logic        m_spike [2];
   int          m_step;

   always #5 clk = ~clk;

   izh_spike_reset #(.V_PEAK(PEAK0), .V_INIT(VINIT), .U_INIT(UINIT), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready),
      .post_v(post_v), .post_u(post_u), .c(c), .d(d), .v_q(v_q), .u_q(u_q),
      .out_valid(out_valid), .out_ready(out_ready), .spike(spike),
      .spike_count(spike_count), .step_count(step_count)
   );

   izh_spike_reset #(.V_PEAK(PEAK1), .V_INIT(VINIT), .U_INIT(UINIT), .CNT_W(CW)) u_dut_z (
      .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(z_in_ready),
      .post_v(post_v), .post_u(post_u), .c(c), .d(d), .v_q(z_v_q), .u_q(z_u_q),
      .out_valid(z_out_valid), .out_ready(out_ready), .spike(z_spike),
      .spike_count(z_spike_count), .step_count(z_step_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic bit is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

   function automatic real f2r(input logic [31:0] f);
      real m;
      int  e;
      e = int'(f[30:23]);
      if (e == 255)    m = 1.0e300;
      else if (e == 0) m = real'(int'(f[22:0])) * (2.0 ** (-149.0));
      else             m = (1.0 + real'(int'(f[22:0])) / 8388608.0) * (2.0 ** real'(e - 127));
      return f[31] ? -m : m;
   endfunction

   // exact real -> nearest-even single, for normal-range values
   function automatic logic [31:0] r2f(input real r);
      real         a, fl, fr;
      int          e;
      int unsigned mi;
      logic        s;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      a  = (a - 1.0) * 8388608.0;
      fl = $floor(a);
      fr = a - fl;
      mi = $rtoi(fl);
      if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
      if (mi == 32'd8388608) begin mi = 0; e++; end
      return {s, 8'(e + 127), mi[22:0]};
   endfunction

   function automatic bit ref_ge(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 1'b0;
      return f2r(a) >= f2r(b);
   endfunction

   function automatic logic [31:0] safe_fp();
      return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_v[k] = VINIT; m_u[k] = UINIT; m_spk[k] = 0; m_spike[k] = 1'b0;
      end
      m_step = 0;
   endtask

   task automatic model_commit(input logic [31:0] pv, pu, cc, dd);
      bit sp;
      for (int k = 0; k < 2; k++) begin
         sp = ref_ge(pv, (k == 0) ? PEAK0 : PEAK1);
         m_spike[k] = sp;
         m_v[k]     = sp ? cc : pv;
         m_u[k]     = sp ? r2f(f2r(pu) + f2r(dd)) : pu;
         if (sp && m_spk[k] < (1 << CW) - 1) m_spk[k]++;
      end
      m_step = (m_step + 1) % (1 << CW);
   endtask

   task automatic chk_out(input string w);
      chk({w, "_v"},     v_q,                  m_v[0]);
      chk({w, "_u"},     u_q,                  m_u[0]);
      chk({w, "_spk"},   32'(spike),           32'(m_spike[0]));
      chk({w, "_scnt"},  32'(spike_count),     32'(m_spk[0]));
      chk({w, "_step"},  32'(step_count),      32'(m_step));
      chk({w, "_zv"},    z_v_q,                m_v[1]);
      chk({w, "_zu"},    z_u_q,                m_u[1]);
      chk({w, "_zspk"},  32'(z_spike),         32'(m_spike[1]));
      chk({w, "_zscnt"}, 32'(z_spike_count),   32'(m_spk[1]));
      chk({w, "_zstep"}, 32'(z_step_count),    32'(m_step));
   endtask

   task automatic chk_hs(input string w, input logic rdy, input logic vld);
      chk({w, "_in_ready"},  32'(in_ready),    32'(rdy));
      chk({w, "_out_valid"}, 32'(out_valid),   32'(vld));
      chk({w, "_zin_ready"}, 32'(z_in_ready),  32'(rdy));
      chk({w, "_zout_vld"},  32'(z_out_valid), 32'(vld));
   endtask

   // called and returns at a negedge with the DUT idle
   task automatic do_step(input logic [31:0] pv, pu, cc, dd, input int bp);
      chk_hs("idle", 1'b1, 1'b0);
      in_valid = 1'b1; post_v = pv; post_u = pu; c = cc; d = dd;
      @(negedge clk);
      in_valid = 1'b0;
      post_v = $urandom; post_u = $urandom; c = $urandom; d = $urandom;
      chk_hs("eval", 1'b0, 1'b0);
      chk_out("eval_old");
      model_commit(pv, pu, cc, dd);
      @(negedge clk);
      chk_hs("hold", 1'b0, 1'b1);
      chk_out("commit");
      out_ready = 1'b0;
      in_valid  = (bp > 0);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk_hs("bp", 1'b0, 1'b1);
         chk_out("bp");
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk_hs("release", 1'b1, 1'b0);
      chk_out("release");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pv;
      logic [31:0] specials [7];
      specials = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00001, 32'h41F00000, 32'h00000001};
      rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      post_v = '0; post_u = '0; c = '0; d = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_out("reset");
      chk_hs("reset", 1'b1, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      do_step(32'h41F00000, 32'hC1500000, 32'hC2820000, 32'h41000000, 0);
      chk("thr_u_exact", u_q, 32'hC0A00000);
      chk("thr_spike", 32'(spike), 32'd1);
      do_step(32'h41EFFFFF, 32'hC1400000, 32'hC2820000, 32'h41000000, 5);
      chk("below_v", v_q, 32'h41EFFFFF);
      do_step(32'hC2200000, 32'hC1400000, 32'hC2820000, 32'h41000000, 1);
      do_step(32'h7FC00000, 32'hC1400000, 32'hC2820000, 32'h41000000, 0);
      chk("nan_v", v_q, 32'h7FC00000);
      do_step(32'h7F800000, 32'hC1400000, 32'hC2820000, 32'h41000000, 2);
      do_step(32'h80000000, 32'hC1400000, 32'hC2820000, 32'h41000000, 0);
      chk("negzero_zpeak", 32'(z_spike), 32'd1);

      // async reset while the step sits in EVAL
      in_valid = 1'b1; post_v = 32'h42000000; post_u = safe_fp(); c = safe_fp(); d = safe_fp();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_out("arst");
      chk_hs("arst", 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_hs("arst_after", 1'b1, 1'b0);
      chk_out("arst_after");

      do_step(32'h42000000, safe_fp(), safe_fp(), safe_fp(), 0);
      // soft clear beats a simultaneous input
      soft_clr = 1'b1; in_valid = 1'b1; post_v = 32'h42000000; post_u = safe_fp();
      @(negedge clk);
      soft_clr = 1'b0; in_valid = 1'b0;
      model_reset();
      chk_out("sclr");
      chk_hs("sclr", 1'b1, 1'b0);
      @(negedge clk);
      chk_hs("sclr_drop", 1'b1, 1'b0);
      chk_out("sclr_drop");

      for (int i = 0; i < 17; i++)
         do_step(32'h42000000, safe_fp(), safe_fp(), safe_fp(), 0);
      chk("sat_spike_count", 32'(spike_count), 32'hF);
      chk("wrap_step_count", 32'(step_count), 32'h1);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       pv = $urandom;
            1:       pv = PEAK0 + 32'($urandom_range(0, 8)) - 32'd4;
            2:       pv = safe_fp();
            default: pv = specials[$urandom_range(0, 6)];
         endcase
         do_step(pv, safe_fp(), $urandom, safe_fp(), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
